// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU operation issue controller with per-opcode latency and registered response (optional feature macro: STICKY_OVERFLOW_EN)
module alu_issue_ctrl #(
    parameter int FAST_LAT = 1,
    parameter int SLOW_LAT = 4,
    parameter int DEST_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_func,
    input  logic [63:0]       req_a,
    input  logic [63:0]       req_b,
    input  logic [DEST_W-1:0] req_dest,
    output logic [63:0]       alu_input1,
    output logic [63:0]       alu_input2,
    output logic [5:0]        alu_function,
    input  logic [63:0]       alu_result,
    input  logic              alu_zero,
    input  logic              alu_compare,
    input  logic              alu_parity_odd,
    input  logic              alu_overflow,
`ifdef STICKY_OVERFLOW_EN
    input  logic              clr_ovf,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_result,
    output logic [DEST_W-1:0] rsp_dest,
    output logic [4:0]        rsp_flags
);

    // Opcode values mirror the opcodes.v encoding used by the ALU.
    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_MUL  = 6'h02;
    localparam logic [5:0] OP_DIV  = 6'h03;
    localparam logic [5:0] OP_MOD  = 6'h04;
    localparam logic [5:0] OP_PWR  = 6'h05;
    localparam logic [5:0] OP_FACT = 6'h06;
    localparam logic [5:0] OP_CE   = 6'h0A;
    localparam logic [5:0] OP_CNE  = 6'h0B;
    localparam logic [5:0] OP_CB   = 6'h0C;
    localparam logic [5:0] OP_CBE  = 6'h0D;
    localparam logic [5:0] OP_CA   = 6'h0E;
    localparam logic [5:0] OP_CAE  = 6'h0F;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int MAX_LAT = (FAST_LAT > SLOW_LAT) ? FAST_LAT : SLOW_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] FAST_CNT = CNT_W'(FAST_LAT - 1);
    localparam logic [CNT_W-1:0] SLOW_CNT = CNT_W'(SLOW_LAT - 1);

    // Multi-cycle ALU operations get the long hold time.
    function automatic logic is_slow_op(input logic [5:0] f);
        return (f == OP_MUL) || (f == OP_DIV) || (f == OP_MOD) ||
               (f == OP_PWR) || (f == OP_FACT);
    endfunction

    // Only comparison ops produce a meaningful compare flag.
    function automatic logic is_cmp_op(input logic [5:0] f);
        return (f == OP_CE) || (f == OP_CNE) || (f == OP_CB) ||
               (f == OP_CBE) || (f == OP_CA) || (f == OP_CAE);
    endfunction

    function automatic logic is_div_op(input logic [5:0] f);
        return (f == OP_DIV) || (f == OP_MOD);
    endfunction

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       in1_q, in1_d;
    logic [63:0]       in2_q, in2_d;
    logic [5:0]        func_q, func_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [63:0]       res_q, res_d;
    logic [DEST_W-1:0] rdest_q, rdest_d;
    logic [4:0]        flags_q, flags_d;
    logic              rvalid_q, rvalid_d;
    logic              capture;

    assign capture = (state_q == ST_EXEC) && (cnt_q == '0);

    // Next-state logic: accept in IDLE, count down in EXEC, hold in RESP until consumed.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        func_d   = func_q;
        dest_d   = dest_q;
        res_d    = res_q;
        rdest_d  = rdest_q;
        flags_d  = flags_q;
        rvalid_d = rvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    in1_d  = req_a;
                    in2_d  = req_b;
                    func_d = req_func;
                    dest_d = req_dest;
                    if (is_div_op(req_func) && (req_b == 64'd0)) begin
                        // Divide by zero is resolved here; the ALU output is never consulted.
                        res_d    = 64'd0;
                        rdest_d  = req_dest;
                        flags_d  = 5'b10001;
                        rvalid_d = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        cnt_d   = is_slow_op(req_func) ? SLOW_CNT : FAST_CNT;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (capture) begin
                    res_d    = alu_result;
                    rdest_d  = dest_q;
                    flags_d  = {1'b0, alu_overflow, alu_parity_odd,
                                alu_compare & is_cmp_op(func_q), alu_zero};
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                rvalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State, operand and response registers; reset drops any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            in1_q    <= 64'd0;
            in2_q    <= 64'd0;
            func_q   <= OP_ADD;
            dest_q   <= '0;
            res_q    <= 64'd0;
            rdest_q  <= '0;
            flags_q  <= 5'd0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            func_q   <= func_d;
            dest_q   <= dest_d;
            res_q    <= res_d;
            rdest_q  <= rdest_d;
            flags_q  <= flags_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef STICKY_OVERFLOW_EN
    logic ovf_sticky_q;

    // Sticky overflow accumulates across operations; a new overflow beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
        end else if (capture && alu_overflow) begin
            ovf_sticky_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky_q <= 1'b0;
        end
    end

    assign rsp_flags = {flags_q[4], flags_q[3] | ovf_sticky_q, flags_q[2:0]};
`else
    assign rsp_flags = flags_q;
`endif

    assign req_ready    = (state_q == ST_IDLE);
    assign alu_input1   = in1_q;
    assign alu_input2   = in2_q;
    assign alu_function = func_q;
    assign rsp_valid    = rvalid_q;
    assign rsp_result   = res_q;
    assign rsp_dest     = rdest_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with an attached ALU model
module tb_alu_issue_ctrl;

    localparam int FAST_LAT = 1;
    localparam int SLOW_LAT = 4;
    localparam int DEST_W   = 5;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_MUL  = 6'h02;
    localparam logic [5:0] OP_DIV  = 6'h03;
    localparam logic [5:0] OP_MOD  = 6'h04;
    localparam logic [5:0] OP_PWR  = 6'h05;
    localparam logic [5:0] OP_FACT = 6'h06;
    localparam logic [5:0] OP_AND  = 6'h07;
    localparam logic [5:0] OP_OR   = 6'h08;
    localparam logic [5:0] OP_XOR  = 6'h09;
    localparam logic [5:0] OP_CE   = 6'h0A;
    localparam logic [5:0] OP_CNE  = 6'h0B;
    localparam logic [5:0] OP_CB   = 6'h0C;
    localparam logic [5:0] OP_CBE  = 6'h0D;
    localparam logic [5:0] OP_CA   = 6'h0E;
    localparam logic [5:0] OP_CAE  = 6'h0F;
    localparam logic [5:0] OP_UNDF = 6'h3F;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_func;
    logic [63:0]       req_a;
    logic [63:0]       req_b;
    logic [DEST_W-1:0] req_dest;
    logic [63:0]       alu_input1;
    logic [63:0]       alu_input2;
    logic [5:0]        alu_function;
    logic [63:0]       alu_result;
    logic              alu_zero;
    logic              alu_compare;
    logic              alu_parity_odd;
    logic              alu_overflow;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [63:0]       rsp_result;
    logic [DEST_W-1:0] rsp_dest;
    logic [4:0]        rsp_flags;
`ifdef STICKY_OVERFLOW_EN
    logic              clr_ovf = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.FAST_LAT(FAST_LAT), .SLOW_LAT(SLOW_LAT), .DEST_W(DEST_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_a(req_a), .req_b(req_b), .req_dest(req_dest),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_function(alu_function),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_compare(alu_compare),
        .alu_parity_odd(alu_parity_odd), .alu_overflow(alu_overflow),
`ifdef STICKY_OVERFLOW_EN
        .clr_ovf(clr_ovf),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_dest(rsp_dest), .rsp_flags(rsp_flags)
    );

    function automatic logic is_cmp(input logic [5:0] f);
        return (f >= OP_CE) && (f <= OP_CAE);
    endfunction

    function automatic logic cmp_true(input logic [5:0] f, input logic [63:0] a, input logic [63:0] b);
        case (f)
            OP_CE:   return a == b;
            OP_CNE:  return a != b;
            OP_CB:   return a < b;
            OP_CBE:  return a <= b;
            OP_CA:   return a > b;
            OP_CAE:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Arithmetic value of an operation; divide by zero yields junk the controller must ignore.
    function automatic logic [63:0] op_value(input logic [5:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] acc;
        case (f)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_MUL: return a * b;
            OP_DIV: return (b == 0) ? 64'hDEAD_BEEF : a / b;
            OP_MOD: return (b == 0) ? 64'hBAD0_0BAD : a % b;
            OP_PWR: begin
                acc = 64'd1;
                for (int i = 0; i < 16; i++) if (64'(i) < b) acc = acc * a;
                return acc;
            end
            OP_FACT: begin
                acc = 64'd1;
                for (int i = 2; i <= 20; i++) if (64'(i) <= a) acc = acc * 64'(i);
                return acc;
            end
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_XOR: return a ^ b;
            OP_CE, OP_CNE, OP_CB, OP_CBE, OP_CA, OP_CAE: return {63'd0, cmp_true(f, a, b)};
            default: return a;
        endcase
    endfunction

    // Combinational ALU model; non-compare ops drive a junk compare bit.
    always_comb begin
        alu_result     = op_value(alu_function, alu_input1, alu_input2);
        alu_zero       = (alu_result == 64'd0);
        alu_parity_odd = ^alu_result;
        alu_compare    = is_cmp(alu_function) ? cmp_true(alu_function, alu_input1, alu_input2)
                                              : alu_result[0];
        alu_overflow   = 1'b0;
        if (alu_function == OP_ADD)
            alu_overflow = (alu_input1[63] == alu_input2[63]) && (alu_result[63] != alu_input1[63]);
        else if (alu_function == OP_SUB)
            alu_overflow = (alu_input1[63] != alu_input2[63]) && (alu_result[63] != alu_input1[63]);
        else if ((alu_function == OP_DIV || alu_function == OP_MOD) && alu_input2 == 0)
            alu_overflow = 1'b1;
    end

    // Reference: what the consumer should see for a request.
    task automatic ref_model(input logic [5:0] f, input logic [63:0] a, input logic [63:0] b,
                             output logic [63:0] res, output logic [4:0] fl, output int lat);
        logic signed [64:0] wide;
        logic ovf;
        if ((f == OP_DIV || f == OP_MOD) && b == 0) begin
            res = 64'd0; fl = 5'b10001; lat = 1;
        end else begin
            res = op_value(f, a, b);
            ovf = 1'b0;
            if (f == OP_ADD) begin
                wide = $signed({a[63], a}) + $signed({b[63], b});
                ovf  = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
            end else if (f == OP_SUB) begin
                wide = $signed({a[63], a}) - $signed({b[63], b});
                ovf  = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
            end
            fl  = {1'b0, ovf, ^res, is_cmp(f) && cmp_true(f, a, b), res == 64'd0};
            lat = ((f == OP_MUL || f == OP_DIV || f == OP_MOD || f == OP_PWR || f == OP_FACT)
                   ? SLOW_LAT : FAST_LAT) + 1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one op, optionally stall the response and poke req_* while busy.
    task automatic run_op(input logic [5:0] f, input logic [63:0] a, input logic [63:0] b,
                          input logic [DEST_W-1:0] d, input int stall, input bit noise,
                          output logic [63:0] res, output logic [4:0] fl,
                          output logic [DEST_W-1:0] rd, output int lat, output int busy);
        int guard;
        rsp_ready = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        check("req_ready_wait", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_func = f; req_a = a; req_b = b; req_dest = d;
        @(posedge clk);
        lat = 1; busy = 0;
        @(negedge clk);
        if (noise) begin
            req_func = OP_ADD; req_a = 64'd1; req_b = 64'd1; req_dest = '1;
        end else begin
            req_valid = 1'b0;
        end
        while (!rsp_valid && lat < 50) begin
            if (!req_ready) busy++;
            check("alu_hold", {alu_function, alu_input1 ^ alu_input2}, {f, a ^ b});
            @(negedge clk);
            lat++;
        end
        res = rsp_result; fl = rsp_flags; rd = rsp_dest;
        for (int i = 0; i < stall; i++) begin
            if (!req_ready) busy++;
            check("stall_hold", {rsp_valid, rsp_flags, rsp_dest, rsp_result[31:0] ^ rsp_result[63:32]},
                  {1'b1, fl, rd, res[31:0] ^ res[63:32]});
            @(negedge clk);
        end
        if (!req_ready) busy++;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("rsp_done", {62'd0, rsp_valid, req_ready}, 64'd1);
    endtask

    typedef struct {
        logic [5:0]        f;
        logic [63:0]       a;
        logic [63:0]       b;
        logic [DEST_W-1:0] d;
        int                stall;
        bit                noise;
        logic [63:0]       res;
        logic [4:0]        fl;
        int                lat;
    } vec_t;

    vec_t vt[12];
    logic [5:0] rand_ops[17];

    initial begin
        logic [63:0]       g_res, e_res, a, b;
        logic [4:0]        g_fl, e_fl;
        logic [DEST_W-1:0] g_d, d;
        logic [5:0]        f;
        int                g_lat, g_busy, e_lat, st;
        bit                saw_rsp;

        vt[0]  = '{OP_ADD, 64'd5, 64'd7, 5'd3, 0, 1'b0, 64'd12, 5'b00000, 2};
        vt[1]  = '{OP_SUB, 64'd3, 64'd3, 5'd9, 0, 1'b0, 64'd0, 5'b00001, 2};
        vt[2]  = '{OP_MUL, 64'd6, 64'd7, 5'd1, 0, 1'b0, 64'd42, 5'b00100, 5};
        vt[3]  = '{OP_DIV, 64'd10, 64'd0, 5'd4, 0, 1'b0, 64'd0, 5'b10001, 1};
        vt[4]  = '{OP_CB, 64'd2, 64'd9, 5'd7, 3, 1'b1, 64'd1, 5'b00110, 2};
        vt[5]  = '{OP_MOD, 64'd10, 64'd0, 5'd2, 0, 1'b0, 64'd0, 5'b10001, 1};
        vt[6]  = '{OP_UNDF, 64'h55, 64'd3, 5'd30, 0, 1'b0, 64'h55, 5'b00000, 2};
        vt[7]  = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd5, 0, 1'b0, 64'h8000_0000_0000_0000, 5'b01100, 2};
        vt[8]  = '{OP_AND, 64'd3, 64'd1, 5'd6, 0, 1'b0, 64'd1, 5'b00100, 2};
        vt[9]  = '{OP_DIV, 64'd100, 64'd7, 5'd8, 1, 1'b1, 64'd14, 5'b00100, 5};
        vt[10] = '{OP_CE, 64'd5, 64'd5, 5'd11, 0, 1'b0, 64'd1, 5'b00110, 2};
        vt[11] = '{OP_CA, 64'd2, 64'd9, 5'd31, 2, 1'b0, 64'd0, 5'b00001, 2};

        rand_ops = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_PWR, OP_FACT, OP_AND, OP_OR,
                     OP_XOR, OP_CE, OP_CNE, OP_CB, OP_CBE, OP_CA, OP_CAE, OP_UNDF};

        rst_n = 1'b0; req_valid = 1'b0; req_func = 6'h2A; req_a = 64'd0; req_b = 64'd0;
        req_dest = '0; rsp_ready = 1'b0;
        #12;
        check("reset_ctrl", {62'd0, req_ready, rsp_valid}, 64'd2);
        check("reset_rsp", {rsp_result[58:0], rsp_flags} | {59'd0, rsp_dest}, 64'd0);
        check("reset_alu_in", alu_input1 | alu_input2, 64'd0);
        check("reset_alu_fn", {58'd0, alu_function}, {58'd0, OP_ADD});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vt[i].f, vt[i].a, vt[i].b, vt[i].d, vt[i].stall, vt[i].noise,
                   g_res, g_fl, g_d, g_lat, g_busy);
            check($sformatf("vec%0d_result", i), g_res, vt[i].res);
            check($sformatf("vec%0d_flags", i), {59'd0, g_fl}, {59'd0, vt[i].fl});
            check($sformatf("vec%0d_dest", i), {59'd0, g_d}, {59'd0, vt[i].d});
            check($sformatf("vec%0d_latency", i), 64'(g_lat), 64'(vt[i].lat));
            check($sformatf("vec%0d_busy", i), 64'(g_busy), 64'(vt[i].lat + vt[i].stall));
        end

        // Reset during a slow op: the op vanishes immediately and never responds.
        @(negedge clk);
        req_valid = 1'b1; req_func = OP_DIV; req_a = 64'd8; req_b = 64'd2; req_dest = 5'd12;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("midop_busy", {63'd0, req_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("midop_reset_async", {62'd0, req_ready, rsp_valid}, 64'd2);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        saw_rsp = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        rsp_ready = 1'b0;
        check("midop_no_rsp", {63'd0, saw_rsp}, 64'd0);

        for (int n = 0; n < 40; n++) begin
            f = rand_ops[$urandom_range(0, 16)];
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (f == OP_PWR) begin a = 64'($urandom_range(0, 15)); b = 64'($urandom_range(0, 8)); end
            if (f == OP_FACT) a = 64'($urandom_range(0, 20));
            if ((f == OP_DIV || f == OP_MOD) && $urandom_range(0, 3) == 0) b = 64'd0;
            if (is_cmp(f) && $urandom_range(0, 2) == 0) b = a;
            if (f == OP_SUB && $urandom_range(0, 3) == 0) b = a;
            d  = DEST_W'($urandom);
            st = $urandom_range(0, 2);
            ref_model(f, a, b, e_res, e_fl, e_lat);
            run_op(f, a, b, d, st, 1'($urandom_range(0, 1)), g_res, g_fl, g_d, g_lat, g_busy);
            check($sformatf("rand%0d_op%0h_result", n, f), g_res, e_res);
            check($sformatf("rand%0d_op%0h_flags", n, f), {59'd0, g_fl}, {59'd0, e_fl});
            check($sformatf("rand%0d_dest", n), {59'd0, g_d}, {59'd0, d});
            check($sformatf("rand%0d_latency", n), 64'(g_lat), 64'(e_lat));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
